dma_controller: RTL

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_controller.sv
// Single-channel word DMA engine with a four-register slave port and a bus
// master that moves one 32-bit word at a time from SRC to DST.
module dma_controller #(
    parameter int LEN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        dma_req_out,
    input  logic        dma_gnt_in,
    output logic [31:0] dma_address_out,
    output logic        dma_read_out,
    output logic        dma_write_out,
    output logic [3:0]  dma_write_mask_out,
    output logic [31:0] dma_write_value_out,
    input  logic [31:0] dma_read_value_in,
    input  logic        dma_ready_in,
    input  logic        dma_fault_in,
    output logic        irq_out,
    output logic [2:0]  debug_state_out
);

    // Master bus handshake: a strobe (dma_read_out / dma_write_out) together
    // with dma_address_out is the request; it is held unchanged until a rising
    // edge samples dma_ready_in or dma_fault_in high, which completes (ready)
    // or aborts (fault, takes priority) the access. dma_req_out is held from
    // REQ through WR, so a grant that drops mid-word does not stall the word.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [1:0] A_SRC  = 2'd0;
    localparam logic [1:0] A_DST  = 2'd1;
    localparam logic [1:0] A_LEN  = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_src;
    logic [31:0]         r_dst;
    logic [LEN_BITS-1:0] r_len;
    logic [31:0]         r_data;
    logic                r_done;
    logic                r_error;
    logic                r_irq_en;

    logic        w_busy;
    logic        w_len_nz;
    logic        w_wr;
    logic        w_wr_src;
    logic        w_wr_dst;
    logic        w_wr_len;
    logic        w_ctrl_wr;
    logic        w_start;
    logic [31:0] w_len_ext;
    logic [31:0] w_src_merged;
    logic [31:0] w_dst_merged;
    logic [31:0] w_len_merged;
    logic        w_req;
    logic        w_rd_strobe;
    logic        w_wr_strobe;
    logic [31:0] w_addr;
    logic        w_capture;
    logic        w_advance;
    logic        w_finish;
    logic        w_fault;
    logic        w_unused;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Only address bits [3:2] select a register; read_in is implied by sel_in.
    assign w_unused = ^{read_in, address_in[31:4], address_in[1:0]};

    assign w_busy    = (r_state != S_IDLE);
    assign w_len_nz  = |r_len;
    assign w_wr      = sel_in && (|write_mask_in);
    assign w_wr_src  = w_wr && (address_in[3:2] == A_SRC);
    assign w_wr_dst  = w_wr && (address_in[3:2] == A_DST);
    assign w_wr_len  = w_wr && (address_in[3:2] == A_LEN);
    assign w_ctrl_wr = sel_in && write_mask_in[0] && (address_in[3:2] == A_CTRL);
    assign w_start   = w_ctrl_wr && write_value_in[0] && !w_busy;

    assign w_len_ext    = 32'(r_len);
    assign w_src_merged = byte_merge(r_src, write_value_in, write_mask_in);
    assign w_dst_merged = byte_merge(r_dst, write_value_in, write_mask_in);
    assign w_len_merged = byte_merge(w_len_ext, write_value_in, write_mask_in);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and master strobes for the current state.
    always_comb begin
        w_next      = r_state;
        w_req       = 1'b0;
        w_rd_strobe = 1'b0;
        w_wr_strobe = 1'b0;
        w_addr      = 32'd0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start && w_len_nz) w_next = S_REQ;
            end
            S_REQ: begin
                w_req = 1'b1;
                if (dma_gnt_in) w_next = S_RD;
            end
            S_RD: begin
                w_req       = 1'b1;
                w_rd_strobe = 1'b1;
                w_addr      = r_src;
                if (dma_fault_in) begin
                    w_fault = 1'b1;
                    w_next  = S_IDLE;
                end else if (dma_ready_in) begin
                    w_capture = 1'b1;
                    w_next    = S_WR;
                end
            end
            S_WR: begin
                w_req       = 1'b1;
                w_wr_strobe = 1'b1;
                w_addr      = r_dst;
                if (dma_fault_in) begin
                    w_fault = 1'b1;
                    w_next  = S_IDLE;
                end else if (dma_ready_in) begin
                    w_advance = 1'b1;
                    w_next    = S_GAP;
                end
            end
            S_GAP: begin
                // Request dropped for this one cycle so the CPU can win arbitration.
                if (!w_len_nz) begin
                    w_finish = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_next = S_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Working registers: CPU-writable only when idle, advanced per completed word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src <= 32'd0;
            r_dst <= 32'd0;
            r_len <= '0;
        end else if (w_advance) begin
            r_src <= r_src + 32'd4;
            r_dst <= r_dst + 32'd4;
            r_len <= r_len - LEN_BITS'(1);
        end else if (!w_busy) begin
            if (w_wr_src) r_src <= w_src_merged & 32'hFFFF_FFFC;
            if (w_wr_dst) r_dst <= w_dst_merged & 32'hFFFF_FFFC;
            if (w_wr_len) r_len <= LEN_BITS'(w_len_merged);
        end
    end

    // Read data latch, replayed as write data for the same word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= 32'd0;
        end else if (w_capture) begin
            r_data <= dma_read_value_in;
        end
    end

    // Status bits; hardware sets are applied last so they win over W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= write_value_in[4];
                if (write_value_in[2]) r_done  <= 1'b0;
                if (write_value_in[3]) r_error <= 1'b0;
            end
            if (w_start) begin
                if (w_len_nz) begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end else begin
                    r_done <= 1'b1;
                end
            end
            if (w_finish) r_done <= 1'b1;
            if (w_fault) begin
                r_error <= 1'b1;
                r_done  <= 1'b0;
            end
        end
    end

    // Slave read mux; zero whenever the slave is not selected.
    always_comb begin
        read_value_out = 32'd0;
        if (sel_in) begin
            case (address_in[3:2])
                A_SRC:   read_value_out = r_src;
                A_DST:   read_value_out = r_dst;
                A_LEN:   read_value_out = w_len_ext;
                default: read_value_out = {27'd0, r_irq_en, r_error, r_done, w_busy, 1'b0};
            endcase
        end
    end

    assign ready_out           = sel_in;
    assign dma_req_out         = w_req;
    assign dma_read_out        = w_rd_strobe;
    assign dma_write_out       = w_wr_strobe;
    assign dma_address_out     = w_addr;
    assign dma_write_mask_out  = w_wr_strobe ? 4'hF : 4'h0;
    assign dma_write_value_out = r_data;
    assign irq_out             = r_done && r_irq_en;
    assign debug_state_out     = r_state;

endmodule
